fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; the producer side of the decoder's pc_in/instruction/uop_valid_in interface.
//  Generates sequential PCs and issues in-order requests to instruction memory.
//  Buffers returned words in a small queue and presents one {pc,instruction} per cycle to decode.
//  Holds its output under system_stall or source_not_ready, and redirects on system_flush.
// PARAMETERS
//  ADDR_WIDTH  32  PC / imem address width (bits)
//  INST_WIDTH  32  instruction word width (bits)
//  RESET_PC    0   first fetch address after reset
//  FQ_DEPTH    4   fetch-queue entries, power of 2, >=2; also the maximum in-flight requests
// PORTS
//  clk             in   1           clock, rising edge
//  reset_n         in   1           asynchronous, active-low reset
//  imem_req_valid  out  1           fetch request valid
//  imem_req_ready  in   1           imem accepts request this cycle
//  imem_req_addr   out  ADDR_WIDTH  word-aligned fetch address
//  imem_rsp_valid  in   1           response valid; responses return in order, >=1 cycle after accept
//  imem_rsp_data   in   INST_WIDTH  instruction word
//  system_stall    in   1           hold the decode-facing output
//  system_flush    in   1           discard all fetched and in-flight work, then redirect
//  redirect_pc     in   ADDR_WIDTH  new PC, sampled when system_flush=1
//  source_not_ready in  1           decoder replaying for a dependency; hold the output
//  pc_out          out  ADDR_WIDTH  PC of the presented instruction (drives decoder pc_in)
//  instruction_out out  INST_WIDTH  presented instruction (drives decoder instruction)
//  uop_valid_out   out  1           presented entry valid (drives decoder uop_valid_in)
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
//   - imem_req_valid=0; uop_valid_out=0; pc_out=0; instruction_out=0.
//  Request issue:
//   - imem_req_valid = !flush && (outstanding + occupancy) < FQ_DEPTH, i.e. credit based; the queue never overflows.
//   - Accept = valid && ready. On accept: fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), outstanding++.
//   - imem_req_addr = fetch_pc, with bits [1:0] always 0; holds stable while valid && !ready.
//  Response:
//   - On imem_rsp_valid: outstanding--.
//   - If drop_cnt>0: word discarded, drop_cnt--.
//   - Otherwise push {pc, data}. The pc is tracked by a separate rsp_pc counter, advanced by 4 per push.
//  Output:
//   - Combinational from the queue head. uop_valid_out = !empty && !system_flush.
//   - pc_out and instruction_out are 0 when empty.
//   - Pop when uop_valid_out && !system_stall && !source_not_ready.
//   - Push and pop in the same cycle are both performed, including when the queue is full.
//   - A response arriving while the queue is empty is visible the next cycle: response-to-decode latency is 1 cycle.
//  Flush (system_flush=1, synchronous, highest priority):
//   - Queue cleared; fetch_pc and rsp_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b0}.
//   - drop_cnt <= outstanding after this cycle's accept and response, so every stale in-flight word is dropped.
//   - A response arriving in the flush cycle is dropped.
//   - No request is issued in the flush cycle; the redirect address is requested from the next cycle.
//   - A flush arriving while drop_cnt>0 accumulates: drop_cnt again equals all outstanding requests.
//  Priority: flush > stall/source_not_ready > pop.
//  Reset asserted mid-transaction clears all state. The imem side is reset by the same reset_n.
// STRUCTURE
//  - Shared package / include (system_param.vh): RESET_PC, FQ_DEPTH, INST_BYTES=4. ADDR_WIDTH and INST_WIDTH already exist there.
//  - Sub-module fetch_queue: synchronous FIFO of {pc,inst}, FQ_DEPTH entries, with push, pop, clear, full, empty, count.
//  - Top level: fetch_pc / rsp_pc, outstanding and drop_cnt counters, credit check, output muxing.
// TESTING
//  1. Reset with imem_req_ready=1 and 1-cycle response -> addresses 0,4,8,... are issued.
//     First uop_valid_out appears 2 cycles after the first accept with pc_out=0; then one uop per cycle.
//  2. Hold system_stall=1 for 6 cycles -> queue fills to 4 and imem_req_valid drops.
//     pc_out/instruction_out stay constant. Release -> pops resume in order with no loss or duplication.
//  3. source_not_ready=1 for 3 cycles at pc_out=0x10 -> pc_out stays 0x10 for all 3 cycles.
//     The next cycle after release shows 0x14.
//  4. With 3 requests outstanding, pulse system_flush, redirect_pc=0x203 -> the 3 stale responses are dropped.
//     The next request address is 0x200; the first valid output has pc_out=0x200.
//  5. Flush in the same cycle as a response and a request accept -> that response is discarded.
//     drop_cnt counts the accepted request; no stale word reaches decode.
//  6. RESET_PC=32'hFFFF_FFF8, sequential fetch -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
//     Assert reset_n=0 mid-stream -> all outputs are 0 immediately (asynchronous).

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: widths, reset PC, queue depth and instruction size.
package fetch_unit_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned INST_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned FQ_DEPTH   = 4;
    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries for decode.
module fetch_queue #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [DATA_WIDTH-1:0]        head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  do_push;
    logic                  do_pop;

    // Status flags and qualified push/pop strobes.
    always_comb begin
        empty     = (cnt == '0);
        full      = (cnt == CNT_W'(DEPTH));
        count     = cnt;
        head_data = mem[rd_ptr];
        do_push   = push && !clear;
        do_pop    = pop && !empty && !clear;
    end

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-based in-order imem requests, fetch queue, decode-facing output.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = fetch_unit_pkg::ADDR_WIDTH,
    parameter int unsigned           INST_WIDTH = fetch_unit_pkg::INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(fetch_unit_pkg::RESET_PC),
    parameter int unsigned           FQ_DEPTH   = fetch_unit_pkg::FQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  system_stall,
    input  logic                  system_flush,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  source_not_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [INST_WIDTH-1:0] instruction_out,
    output logic                  uop_valid_out
);

    localparam int unsigned           CNT_W      = $clog2(FQ_DEPTH + 1);
    localparam int unsigned           SUM_W      = CNT_W + 1;
    localparam int unsigned           ENTRY_W    = ADDR_WIDTH + INST_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INST_BYTES - 1);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_nxt;
    logic [CNT_W-1:0]      drop_cnt;
    logic [CNT_W-1:0]      fq_count;
    logic                  fq_full;
    logic                  fq_empty;
    logic [ENTRY_W-1:0]    fq_head;
    logic                  req_fire;
    logic                  rsp_drop;
    logic                  fq_push;
    logic                  fq_pop;

    // Request credit, response routing and decode-facing output muxing.
    always_comb begin
        imem_req_valid  = 1'b0;
        imem_req_addr   = fetch_pc & ALIGN_MASK;
        req_fire        = 1'b0;
        rsp_drop        = 1'b0;
        fq_push         = 1'b0;
        fq_pop          = 1'b0;
        uop_valid_out   = 1'b0;
        pc_out          = '0;
        instruction_out = '0;

        // Every in-flight request owns a queue slot, so the queue cannot overflow.
        imem_req_valid = reset_n && !system_flush &&
                         ((SUM_W'(outstanding) + SUM_W'(fq_count)) < SUM_W'(FQ_DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_drop = imem_rsp_valid && (system_flush || (drop_cnt != '0));
        uop_valid_out = !fq_empty && !system_flush;
        fq_pop        = uop_valid_out && !system_stall && !source_not_ready;
        fq_push       = imem_rsp_valid && !rsp_drop && (!fq_full || fq_pop);

        if (!fq_empty) begin
            pc_out          = fq_head[ENTRY_W-1:INST_WIDTH];
            instruction_out = fq_head[INST_WIDTH-1:0];
        end

        outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    end

    // PC counters, in-flight count and stale-response drop count; flush redirects everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC & ALIGN_MASK;
            rsp_pc      <= RESET_PC & ALIGN_MASK;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (system_flush) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
                rsp_pc   <= redirect_pc & ALIGN_MASK;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (fq_push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    fetch_queue #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fq_push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (fq_pop),
        .clear     (system_flush),
        .head_data (fq_head),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count)
    );

endmodule
